// File: rtl/ram_burst_pkg.sv
// Shared encodings for the burst RAM controller: command modes, FSM states, skid FIFO depth.
package ram_burst_pkg;

    localparam logic [1:0] MODE_READ    = 2'b00;
    localparam logic [1:0] MODE_WRITE   = 2'b01;
    localparam logic [1:0] MODE_FILL    = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    localparam int unsigned FIFO_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_FILL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ram_burst_skid.sv
// Two-entry valid/ready FIFO that decouples the 1-cycle RAM read latency from the read stream.
module ram_burst_skid
    import ram_burst_pkg::*;
#(
    parameter int p_data_width = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [p_data_width-1:0] push_data_i,
    input  logic                    pop_i,
    output logic [p_data_width-1:0] data_o,
    output logic                    valid_o,
    output logic [1:0]              occ_o
);

    logic [p_data_width-1:0] entry_q [FIFO_DEPTH];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              occ_q;
    logic                    do_push;
    logic                    do_pop;

    // The issuer never pushes into a full FIFO unless it is draining in the same cycle.
    assign do_pop  = pop_i && (occ_q != 2'd0);
    assign do_push = push_i && ((occ_q != 2'd2) || do_pop);

    assign data_o  = entry_q[rd_ptr_q];
    assign valid_o = (occ_q != 2'd0);
    assign occ_o   = occ_q;

    // Storage, pointers and occupancy; cleared on reset so the data output reads zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            if (do_push) begin
                entry_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Single-port synchronous RAM fronted by a burst engine: one start command streams
// a region out (READ), streams words in (WRITE) or writes a constant (FILL).
module ram_burst_ctrl
    import ram_burst_pkg::*;
#(
    parameter int p_data_width    = 8,
    parameter int p_address_width = 10,
    parameter int p_len_width     = 8
) (
    input  logic                       i_w_clk,
    input  logic                       i_w_rst_n,
    input  logic                       i_w_start,
    input  logic [1:0]                 i_w_mode,
    input  logic [p_address_width-1:0] i_w_base_addr,
    input  logic [p_len_width-1:0]     i_w_len,
    input  logic [p_data_width-1:0]    i_w_fill_data,
    input  logic [p_data_width-1:0]    i_w_wr_data,
    input  logic                       i_w_wr_valid,
    output logic                       o_w_wr_ready,
    output logic [p_data_width-1:0]    o_w_rd_data,
    output logic                       o_w_rd_valid,
    input  logic                       i_w_rd_ready,
    output logic                       o_w_busy,
    output logic                       o_w_done,
    output logic                       o_w_error
);

    localparam int unsigned                DEPTH    = 2 ** p_address_width;
    localparam logic [p_len_width-1:0]     LEN_ONE  = p_len_width'(1);
    localparam logic [p_address_width-1:0] ADDR_ONE = p_address_width'(1);

    logic [p_data_width-1:0]    mem_q [DEPTH];
    logic [p_data_width-1:0]    rd_word_q;

    state_t                     state_q, state_d;
    logic [p_address_width-1:0] addr_q, addr_d;
    logic [p_len_width-1:0]     len_q, len_d;
    logic [p_len_width-1:0]     issued_q, issued_d;
    logic [p_len_width-1:0]     returned_q, returned_d;
    logic [p_data_width-1:0]    fill_q, fill_d;
    logic                       error_q, error_d;
    logic                       inflight_q, inflight_d;

    logic                       ram_we;
    logic                       ram_re;
    logic [p_data_width-1:0]    ram_wdata;

    logic                       fifo_valid;
    logic                       fifo_pop;
    logic [1:0]                 fifo_occ;
    logic [2:0]                 slots_used;
    logic                       last_beat;

    ram_burst_skid #(.p_data_width(p_data_width)) u_skid (
        .clk_i       (i_w_clk),
        .rst_ni      (i_w_rst_n),
        .push_i      (inflight_q),
        .push_data_i (rd_word_q),
        .pop_i       (fifo_pop),
        .data_o      (o_w_rd_data),
        .valid_o     (fifo_valid),
        .occ_o       (fifo_occ)
    );

    assign fifo_pop     = fifo_valid && i_w_rd_ready;
    // Occupancy is counted after this cycle's pop so a steadily drained stream sustains one word per cycle.
    assign slots_used   = {1'b0, fifo_occ} - {2'b00, fifo_pop} + {2'b00, inflight_q};
    assign last_beat    = (returned_q == (len_q - LEN_ONE));

    assign o_w_rd_valid = fifo_valid;
    assign o_w_wr_ready = (state_q == ST_WRITE);
    assign o_w_busy     = (state_q != ST_IDLE);
    assign o_w_done     = (state_q == ST_DONE);
    assign o_w_error    = error_q;

    // Next-state, counter updates and RAM strobes.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        fill_d     = fill_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        error_d    = 1'b0;
        inflight_d = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_wdata  = fill_q;

        case (state_q)
            ST_IDLE: begin
                if (i_w_start) begin
                    if (i_w_mode == MODE_ILLEGAL) begin
                        error_d = 1'b1;
                    end else begin
                        addr_d     = i_w_base_addr;
                        len_d      = i_w_len;
                        fill_d     = i_w_fill_data;
                        issued_d   = '0;
                        returned_d = '0;
                        if (i_w_len == '0)                 state_d = ST_DONE;
                        else if (i_w_mode == MODE_READ)    state_d = ST_READ;
                        else if (i_w_mode == MODE_WRITE)   state_d = ST_WRITE;
                        else                               state_d = ST_FILL;
                    end
                end
            end
            ST_READ: begin
                if ((slots_used < 3'(FIFO_DEPTH)) && (issued_q != len_q)) begin
                    ram_re     = 1'b1;
                    inflight_d = 1'b1;
                    addr_d     = addr_q + ADDR_ONE;
                    issued_d   = issued_q + LEN_ONE;
                end
                if (fifo_pop) begin
                    returned_d = returned_q + LEN_ONE;
                    if (last_beat) state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (i_w_wr_valid) begin
                    ram_we     = 1'b1;
                    ram_wdata  = i_w_wr_data;
                    addr_d     = addr_q + ADDR_ONE;
                    returned_d = returned_q + LEN_ONE;
                    if (last_beat) state_d = ST_DONE;
                end
            end
            ST_FILL: begin
                ram_we     = 1'b1;
                addr_d     = addr_q + ADDR_ONE;
                returned_d = returned_q + LEN_ONE;
                if (last_beat) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state register; reset abandons any burst in progress.
    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            fill_q     <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            error_q    <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            fill_q     <= fill_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            error_q    <= error_d;
            inflight_q <= inflight_d;
        end
    end

    // RAM array: synchronous write and registered read, contents untouched by reset.
    always_ff @(posedge i_w_clk) begin
        if (ram_we) mem_q[addr_q] <= ram_wdata;
        if (ram_re) rd_word_q <= mem_q[addr_q];
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed and randomized bench for ram_burst_ctrl against a flat-array memory model.
module tb_ram_burst_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int LW    = 8;
    localparam int DEPTH = 1024;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic [1:0]    mode     = 2'b00;
    logic [AW-1:0] base     = '0;
    logic [LW-1:0] len      = '0;
    logic [DW-1:0] fill     = '0;
    logic [DW-1:0] wr_data  = '0;
    logic          wr_valid = 1'b0;
    logic          rd_ready = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;
    logic          done;
    logic          error;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] wbuf [256];
    int            n_cmp  = 0;
    int            n_fail = 0;

    ram_burst_ctrl #(.p_data_width(DW), .p_address_width(AW), .p_len_width(LW)) dut (
        .i_w_clk       (clk),
        .i_w_rst_n     (rst_n),
        .i_w_start     (start),
        .i_w_mode      (mode),
        .i_w_base_addr (base),
        .i_w_len       (len),
        .i_w_fill_data (fill),
        .i_w_wr_data   (wr_data),
        .i_w_wr_valid  (wr_valid),
        .o_w_wr_ready  (wr_ready),
        .o_w_rd_data   (rd_data),
        .o_w_rd_valid  (rd_valid),
        .i_w_rd_ready  (rd_ready),
        .o_w_busy      (busy),
        .o_w_done      (done),
        .o_w_error     (error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] m, input int b, input int l, input logic [DW-1:0] f);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        base  = AW'(b);
        len   = LW'(l);
        fill  = f;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_fill(input int b, input int l, input logic [DW-1:0] f);
        int k;
        bit seen = 0;
        issue(2'b10, b, l, f);
        chk("fill_busy", busy, 1);
        for (k = 0; k < 400; k++) begin
            if (done) begin seen = 1; break; end
            @(negedge clk);
        end
        for (int i = 0; i < l; i++) ref_mem[(b + i) % DEPTH] = f;
        chk("fill_done_seen", seen, 1);
        chk("fill_latency", k, l);
        @(negedge clk);
        chk("fill_done_single", done, 0);
        chk("fill_idle", busy, 0);
    endtask

    // vmode: 0 valid always high, 1 toggling 1,0,1,..., 2 random
    task automatic do_write(input int b, input int l, input int vmode);
        int k;
        int idx = 0;
        int last_hs = -1;
        bit seen = 0;
        bit v;
        issue(2'b01, b, l, 8'h00);
        chk("wr_busy", busy, 1);
        for (k = 0; k < 400; k++) begin
            if (done) begin seen = 1; break; end
            chk("wr_ready", wr_ready, 1);
            case (vmode)
                0:       v = 1'b1;
                1:       v = (k % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            wr_valid = v;
            wr_data  = wbuf[idx % 256];
            if (v) begin
                if (idx < l) ref_mem[(b + idx) % DEPTH] = wbuf[idx % 256];
                idx++;
                last_hs = k;
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("wr_done_seen", seen, 1);
        chk("wr_count", idx, l);
        chk("wr_done_latency", k, last_hs + 1);
        @(negedge clk);
        chk("wr_done_single", done, 0);
        chk("wr_idle", busy, 0);
        chk("wr_ready_idle", wr_ready, 0);
    endtask

    // rmode: 0 ready always high, 1 random, 2 low for 3 cycles from the first valid
    task automatic do_read(input int b, input int l, input int rmode);
        int k;
        int idx = 0;
        int first_k = -1;
        bit seen = 0;
        bit pv = 0;
        bit pr = 0;
        bit rdy;
        logic [DW-1:0] pd = '0;
        issue(2'b00, b, l, 8'h00);
        chk("rd_busy", busy, 1);
        for (k = 0; k < 400; k++) begin
            if (done) begin seen = 1; break; end
            if (rd_valid) begin
                if (first_k < 0) first_k = k;
                chk("rd_data", rd_data, ref_mem[(b + idx) % DEPTH]);
                if (pv && !pr) chk("rd_data_hold", rd_data, pd);
            end else if (pv && !pr) begin
                chk("rd_valid_hold", rd_valid, 1);
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = !(first_k >= 0 && (k - first_k) < 3);
            endcase
            rd_ready = rdy;
            pv = rd_valid;
            pr = rdy;
            pd = rd_data;
            if (rd_valid && rdy) idx++;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        chk("rd_done_seen", seen, 1);
        chk("rd_count", idx, l);
        if (l > 0) chk("rd_first_latency", first_k, 2);
        else chk("zero_len_latency", k, 0);
        if (rmode == 0 && l > 0) chk("rd_stream_latency", k, l + 2);
        @(negedge clk);
        chk("rd_done_single", done, 0);
        chk("rd_idle", busy, 0);
        chk("rd_valid_idle", rd_valid, 0);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;

        // give every address a known random value
        for (int i = 0; i < 5; i++) do_fill(i * 255, 255, 8'($urandom));

        // fill then read
        do_fill(2, 4, 8'hA5);
        do_read(2, 4, 0);

        // write stream with toggling valid, then read back
        wbuf[0] = 8'd7; wbuf[1] = 8'd8; wbuf[2] = 8'd9;
        do_write(5, 3, 1);
        do_read(5, 3, 0);

        // backpressure
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(i + 1);
        do_write(20, 4, 0);
        do_read(20, 4, 2);

        // address wrap
        wbuf[0] = 8'd10; wbuf[1] = 8'd11; wbuf[2] = 8'd12;
        do_write(1023, 3, 0);
        do_read(1023, 3, 1);

        // illegal mode: error pulse, no state change, no RAM change
        issue(2'b11, 5, 3, 8'hFF);
        chk("ill_error", error, 1);
        chk("ill_busy", busy, 0);
        @(negedge clk);
        chk("ill_error_single", error, 0);
        chk("ill_busy_after", busy, 0);
        chk("ill_done", done, 0);
        do_read(5, 3, 0);

        // zero length in every legal mode
        do_read(2, 0, 0);
        do_write(5, 0, 0);
        do_fill(20, 0, 8'h5A);
        do_read(2, 4, 1);
        do_read(20, 4, 0);

        // async reset after 2 of 5 writes
        for (int i = 0; i < 5; i++) wbuf[i] = 8'(8'h30 + i);
        issue(2'b01, 100, 5, 8'h00);
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = wbuf[i];
            ref_mem[100 + i] = wbuf[i];
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr_ready", wr_ready, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        wr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);
        do_read(100, 3, 0);

        // randomized bursts
        for (int it = 0; it < 12; it++) begin
            int op;
            int b;
            int l;
            op = int'($urandom_range(0, 2));
            b  = int'($urandom_range(0, DEPTH - 1));
            l  = int'($urandom_range(1, 16));
            case (op)
                0: do_read(b, l, 1);
                1: begin
                    for (int i = 0; i < l; i++) wbuf[i] = 8'($urandom);
                    do_write(b, l, 2);
                    do_read(b, l, 1);
                end
                default: do_fill(b, l, 8'($urandom));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
